reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DW, default 16: data width of every register instance fed by this block.
REQ-002 Parameter NREG, default 8: number of register instances driven; AW = log2(NREG) = 3.
REQ-003 Parameter NREQ, default 3: number of write requesters (0 = ALU, 1 = memory load, 2 = immediate load).
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 stall  in  1: when high, no new grant is issued that cycle.
REQ-007 req  in  NREQ: per-requester write request; held high until the matching gnt bit is seen.
REQ-008 req_addr0..2  in  AW each: target register index of each requester.
REQ-009 req_data0..2  in  DW each: write data of each requester.
REQ-010 gnt  out  NREQ: registered one-hot grant, high for exactly one cycle per accepted write.
REQ-011 reg_en  out  NREG: registered one-hot enable, wired to the en inputs of the register instances.
REQ-012 reg_source  out  DW: registered write data, wired to the source inputs of all register instances.
REQ-013 last_gnt  out  2: index of the most recently granted requester (round-robin pointer, for debug).

Function
REQ-014 Each cycle, eligible[i] = req[i] AND NOT gnt[i]: a requester granted in the previous cycle is ignored for one cycle, so a req still high after its grant is never accepted twice.
REQ-015 If stall = 0 and any eligible bit is set, the winner is the first eligible requester searching from (last_gnt+1) mod NREQ upward with wrap-around.
REQ-016 On a win by requester w at edge T: in cycle T+1, gnt = onehot(w), reg_en = onehot(req_addr_w), reg_source = req_data_w, last_gnt = w; latency is exactly one cycle.
REQ-017 If stall = 1 or no eligible request, then at the next edge gnt = 0, reg_en = 0, reg_source holds its previous value, and last_gnt is unchanged.
REQ-018 At most one gnt bit and at most one reg_en bit are high in any cycle.
REQ-019 Two requesters targeting the same register are serialised in round-robin order; the later grant's data is what the register finally holds.
REQ-020 A request whose req drops before it is granted is discarded without side effects.
REQ-021 Sustained throughput is one write per cycle when two or more requesters are active; a single requester gets at most one write every two cycles (per REQ-014).
REQ-022 The block contains no combinational path from inputs to outputs.

Reset
REQ-023 While rst = 1 at a rising edge: gnt = 0, reg_en = 0, reg_source = 0, last_gnt = NREQ-1 = 2, so requester 0 has highest priority first after reset.
REQ-024 Reset asserted mid-operation cancels the pending grant; no reg_en pulse is produced in the cycle after the reset edge.
REQ-025 A req held high across reset is arbitrated normally starting at the first edge with rst = 0.

Structure
REQ-026 Package reg_arb_pkg holds DW, NREG, AW and NREQ, plus the requester index constants REQ_ALU = 0, REQ_MEM = 1 and REQ_IMM = 2.
REQ-027 Round-robin selection is a combinational sub-module rr_pick3 (inputs eligible and last_gnt; outputs valid and winner index); all registered state stays in reg_write_arbiter.

Verification
REQ-028 Reset: rst = 1 for 2 cycles with req = 3'b111 -> gnt = 0, reg_en = 0, reg_source = 0, last_gnt = 2; on the first edge with rst = 0, requester 0 wins.
REQ-029 Single request: req = 3'b010, addr1 = 5, data1 = 16'hBEEF held for 4 cycles -> gnt = 3'b010 and reg_en = 8'b0010_0000 with reg_source = 16'hBEEF in alternating cycles only, never on two consecutive cycles.
REQ-030 Round-robin: req = 3'b111 held continuously from reset -> grant order 0, 1, 2, 0, 1, 2 with a gnt pulse every cycle.
REQ-031 Stall: req = 3'b100 and stall = 1 for 3 cycles, then stall = 0 -> no gnt during the stall; gnt = 3'b100 one cycle after stall drops.
REQ-032 Address conflict: req0 (addr 3, 16'h1111) and req2 (addr 3, 16'h2222) raised together after reset -> reg_en = 8'b0000_1000 twice; data 16'h1111 then 16'h2222, and the downstream register ends at 16'h2222.
REQ-033 Mid-operation reset: rst = 1 on the edge after a grant is decided -> no reg_en pulse follows, and last_gnt = 2.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared sizing and requester identifiers for the register-file write arbiter.
// Also holds the wrap-around step used by the round-robin search.
package reg_arb_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);
    localparam int NREQ = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_IMM = 2;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t next_idx(input req_idx_t idx);
        return (idx >= req_idx_t'(NREQ - 1)) ? req_idx_t'(0) : req_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three requesters.
// The search starts just after last_gnt and wraps around.
module rr_pick3
    import reg_arb_pkg::*;
(
    input  logic [NREQ-1:0] eligible,
    input  req_idx_t        last_gnt,
    output logic            valid,
    output req_idx_t        winner
);

    req_idx_t cand;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        valid  = 1'b0;
        winner = last_gnt;
        cand   = next_idx(last_gnt);
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && eligible[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
            cand = next_idx(cand);
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter serialising ALU, memory-load and immediate writes onto
// a shared register-file write port; all outputs are registered.
module reg_write_arbiter #(
    parameter int DW   = reg_arb_pkg::DW,
    parameter int NREG = reg_arb_pkg::NREG,
    parameter int NREQ = reg_arb_pkg::NREQ,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [NREQ-1:0] req,
    input  logic [AW-1:0]   req_addr0,
    input  logic [AW-1:0]   req_addr1,
    input  logic [AW-1:0]   req_addr2,
    input  logic [DW-1:0]   req_data0,
    input  logic [DW-1:0]   req_data1,
    input  logic [DW-1:0]   req_data2,
    output logic [NREQ-1:0] gnt,
    output logic [NREG-1:0] reg_en,
    output logic [DW-1:0]   reg_source,
    output logic [1:0]      last_gnt
);

    import reg_arb_pkg::*;

    logic [NREQ-1:0] eligible;
    logic            pick_valid;
    req_idx_t        pick_idx;
    logic [AW-1:0]   addr_sel [NREQ];
    logic [DW-1:0]   data_sel [NREQ];

    assign addr_sel[REQ_ALU] = req_addr0;
    assign addr_sel[REQ_MEM] = req_addr1;
    assign addr_sel[REQ_IMM] = req_addr2;
    assign data_sel[REQ_ALU] = req_data0;
    assign data_sel[REQ_MEM] = req_data1;
    assign data_sel[REQ_IMM] = req_data2;

    // A requester just granted still has req high this cycle; mask it off.
    assign eligible = req & ~gnt;

    rr_pick3 u_pick (
        .eligible (eligible),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .winner   (pick_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            gnt        <= '0;
            reg_en     <= '0;
            reg_source <= '0;
            last_gnt   <= 2'(NREQ - 1);
        end else if (!stall && pick_valid) begin
            gnt        <= NREQ'(1) << pick_idx;
            reg_en     <= NREG'(1) << addr_sel[pick_idx];
            reg_source <= data_sel[pick_idx];
            last_gnt   <= pick_idx;
        end else begin
            gnt    <= '0;
            reg_en <= '0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural arbitration model and a model of the downstream register file.
module tb_reg_write_arbiter;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int NREQ = 3;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [AW-1:0]   addr [NREQ];
    logic [DW-1:0]   data [NREQ];
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] reg_en;
    logic [DW-1:0]   reg_source;
    logic [1:0]      last_gnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] dut_regs [NREG];

    int              m_last = NREQ - 1;
    logic [NREQ-1:0] m_gnt  = '0;
    logic [NREG-1:0] m_en   = '0;
    logic [DW-1:0]   m_src  = '0;
    logic [DW-1:0]   m_regs [NREG];

    reg_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req        (req),
        .req_addr0  (addr[0]),
        .req_addr1  (addr[1]),
        .req_addr2  (addr[2]),
        .req_data0  (data[0]),
        .req_data1  (data[1]),
        .req_data2  (data[2]),
        .gnt        (gnt),
        .reg_en     (reg_en),
        .reg_source (reg_source),
        .last_gnt   (last_gnt)
    );

    always #5 clk = ~clk;

    // Downstream register instances fed by the arbiter outputs.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (reg_en[i] === 1'b1) dut_regs[i] <= reg_source;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: registers capture the previous pulse, then the next grant is
    // chosen as the first eligible requester in rotation after the last winner.
    task automatic model_step();
        int order[$];
        int w;
        for (int i = 0; i < NREG; i++)
            if (m_en[i]) m_regs[i] = m_src;
        if (rst) begin
            m_gnt  = '0;
            m_en   = '0;
            m_src  = '0;
            m_last = NREQ - 1;
        end else begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) order.push_back((m_last + k) % NREQ);
            if (!stall) begin
                foreach (order[j]) begin
                    if (w < 0 && req[order[j]] && !m_gnt[order[j]]) w = order[j];
                end
            end
            if (w >= 0) begin
                m_gnt  = NREQ'(1 << w);
                m_en   = NREG'(1 << addr[w]);
                m_src  = data[w];
                m_last = w;
            end else begin
                m_gnt = '0;
                m_en  = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("reg_en", 32'(reg_en), 32'(m_en));
        check("reg_source", 32'(reg_source), 32'(m_src));
        check("last_gnt", 32'(last_gnt), 32'(m_last));
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        check("en_onehot", 32'($countones(reg_en) <= 1), 32'd1);
        for (int i = 0; i < NREG; i++)
            check($sformatf("reg%0d", i), 32'(dut_regs[i]), 32'(m_regs[i]));
    endtask

    task automatic do_reset(input logic [NREQ-1:0] req_val);
        rst   = 1'b1;
        stall = 1'b0;
        req   = req_val;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp   [6];
        logic [NREQ-1:0] one_exp  [4];
        logic [NREG-1:0] one_en   [4];
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        one_exp = '{3'b010, 3'b000, 3'b010, 3'b000};
        one_en  = '{8'h20, 8'h00, 8'h20, 8'h00};

        for (int i = 0; i < NREQ; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end
        for (int i = 0; i < NREG; i++) begin
            dut_regs[i] = '0;
            m_regs[i]   = '0;
        end

        // Reset with all requests up, then round-robin order under full load.
        do_reset(3'b111);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_en", 32'(reg_en), 32'd0);
        check("rst_src", 32'(reg_source), 32'd0);
        check("rst_last", 32'(last_gnt), 32'd2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
        end

        // Lone requester: granted every other cycle only.
        do_reset(3'b000);
        req     = 3'b010;
        addr[1] = 3'd5;
        data[1] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("single_gnt%0d", i), 32'(gnt), 32'(one_exp[i]));
            check($sformatf("single_en%0d", i), 32'(reg_en), 32'(one_en[i]));
            check($sformatf("single_src%0d", i), 32'(reg_source), 32'hBEEF);
        end
        req = 3'b000;

        // Stall blocks grants; release gives the grant one edge later.
        do_reset(3'b000);
        req   = 3'b100;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_gnt%0d", i), 32'(gnt), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("unstall_gnt", 32'(gnt), 32'(3'b100));
        req = 3'b000;

        // Two writers to the same register: serialised, later data wins.
        do_reset(3'b000);
        addr[0] = 3'd3;
        data[0] = 16'h1111;
        addr[2] = 3'd3;
        data[2] = 16'h2222;
        req     = 3'b101;
        tick();
        check("conf_gnt0", 32'(gnt), 32'(3'b001));
        check("conf_en0", 32'(reg_en), 32'h08);
        check("conf_src0", 32'(reg_source), 32'h1111);
        req = 3'b100;
        tick();
        check("conf_gnt1", 32'(gnt), 32'(3'b100));
        check("conf_en1", 32'(reg_en), 32'h08);
        check("conf_src1", 32'(reg_source), 32'h2222);
        req = 3'b000;
        tick();
        check("conf_reg3", 32'(dut_regs[3]), 32'h2222);

        // Reset on the edge where a grant was about to be issued.
        do_reset(3'b000);
        req = 3'b011;
        tick();
        check("mid_gnt_pre", 32'(gnt), 32'(3'b001));
        rst = 1'b1;
        tick();
        check("mid_en", 32'(reg_en), 32'd0);
        check("mid_gnt", 32'(gnt), 32'd0);
        check("mid_last", 32'(last_gnt), 32'd2);
        rst = 1'b0;
        tick();
        check("mid_regnt", 32'(gnt), 32'(3'b001));
        req = 3'b000;

        // Randomized traffic, including occasional stalls and resets.
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            req   = NREQ'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                addr[i] = AW'($urandom_range(0, NREG - 1));
                data[i] = DW'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
